// File: rtl/stack_arb_pkg.sv
// Shared types and defaults for the stack arbiter: FSM state enum, default
// requester count and data width, and the winner-index width helper.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture
    } state_e;

    localparam int unsigned NREQ_DEFAULT  = 2;
    localparam int unsigned WIDTH_DEFAULT = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first eligible requester after
// last_winner (wrapping) wins; any_valid flags that some requester is eligible.
module rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [IDX_W-1:0] last_winner,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    logic             hi_any, lo_any;
    logic [IDX_W-1:0] hi_idx, lo_idx;

    // Two passes folded into one descending loop: the lowest index above
    // last_winner has priority, otherwise the lowest index at or below it.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                if (j > int'(last_winner)) begin
                    hi_any = 1'b1;
                    hi_idx = IDX_W'(j);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = IDX_W'(j);
                end
            end
        end
        winner    = hi_any ? hi_idx : lo_idx;
        any_valid = hi_any | lo_any;
    end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack between NREQ push/pop requesters.
// Optional sticky protocol-error output enabled by defining STACK_ARB_ERR_EN.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_push,
    input  logic [NREQ-1:0]       req_pop,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [WIDTH-1:0]      stk_value_in,
    input  logic [WIDTH-1:0]      stk_value_out,
    input  logic                  stk_full,
    input  logic                  stk_empty
`ifdef STACK_ARB_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned IDX_W = idx_width(NREQ);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic             is_pop_q, is_pop_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             stk_push_q, stk_push_d;
    logic             stk_pop_q, stk_pop_d;
    logic [WIDTH-1:0] value_in_q, value_in_d;

    logic [WIDTH-1:0] req_word [NREQ];
    logic [NREQ-1:0]  eligible;
    logic [IDX_W-1:0] pick;
    logic             pick_any;

    // Requests with both push and pop set are never eligible.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_word[i] = req_data[i*WIDTH +: WIDTH];
            eligible[i] = (req_push[i] && !req_pop[i] && !stk_full) ||
                          (req_pop[i] && !req_push[i] && !stk_empty);
        end
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .eligible    (eligible),
        .last_winner (last_q),
        .winner      (pick),
        .any_valid   (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        is_pop_d    = is_pop_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        stk_push_d  = 1'b0;
        stk_pop_d   = 1'b0;
        value_in_d  = value_in_q;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d     = StIssue;
                    last_d      = pick;
                    win_d       = pick;
                    is_pop_d    = req_pop[pick];
                    gnt_d[pick] = 1'b1;
                    if (req_pop[pick]) begin
                        stk_pop_d = 1'b1;
                    end else begin
                        stk_push_d = 1'b1;
                        value_in_d = req_word[pick];
                    end
                end
            end
            StIssue: begin
                state_d = is_pop_q ? StCapture : StIdle;
            end
            StCapture: begin
                state_d            = StIdle;
                rsp_valid_d[win_q] = 1'b1;
                rsp_data_d         = stk_value_out;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            last_q      <= IDX_W'(NREQ - 1);
            win_q       <= '0;
            is_pop_q    <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            stk_push_q  <= 1'b0;
            stk_pop_q   <= 1'b0;
            value_in_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            is_pop_q    <= is_pop_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            stk_push_q  <= stk_push_d;
            stk_pop_q   <= stk_pop_d;
            value_in_q  <= value_in_d;
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign stk_push     = stk_push_q;
    assign stk_pop      = stk_pop_q;
    assign stk_value_in = value_in_q;

`ifdef STACK_ARB_ERR_EN
    logic [NREQ-1:0] illegal;
    logic            err_q, err_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            illegal[i] = (req_push[i] && req_pop[i]) ||
                         (req_push[i] && stk_full) ||
                         (req_pop[i] && stk_empty);
        end
        err_d = err_q | ((state_q == StIdle) && (|illegal));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the data width of the shared stack.
REQ-003 clk  input  1  single clock; all logic samples on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_push  input  NREQ  per-requester push request, held until granted.
REQ-006 req_pop  input  NREQ  per-requester pop request, held until granted.
REQ-007 req_data  input  NREQ*WIDTH  per-requester push data, slice i belongs to requester i.
REQ-008 gnt  output  NREQ  one-hot, one-cycle grant pulse.
REQ-009 rsp_valid  output  NREQ  one-hot, one-cycle pop-data-valid pulse.
REQ-010 rsp_data  output  WIDTH  pop data, meaningful only while rsp_valid is nonzero.
REQ-011 stk_push, stk_pop  output  1 each  drive the shared stack's push and pop inputs.
REQ-012 stk_value_in  output  WIDTH  drives the stack's value_in.
REQ-013 stk_value_out  input  WIDTH  the stack's value_out.
REQ-014 stk_full, stk_empty  input  1 each  the stack's full and empty flags.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE and CAPTURE, encoded in the package enum.
REQ-016 In IDLE, requester i SHALL be eligible when it has exactly one of push or pop asserted, with push eligible only if !stk_full and pop eligible only if !stk_empty.
REQ-017 In IDLE, arbitration SHALL be round-robin: the search starts at last_winner+1 modulo NREQ, and the first eligible requester wins.
REQ-018 If any requester is eligible in IDLE, the next cycle SHALL be ISSUE.
REQ-019 In ISSUE, the block SHALL drive gnt[winner]=1 for exactly one cycle and assert exactly one of stk_push/stk_pop, all from registers.
REQ-020 On a push in ISSUE, stk_value_in SHALL equal the winner's req_data slice as registered at arbitration.
REQ-021 After ISSUE, a push SHALL return to IDLE and a pop SHALL go to CAPTURE.
REQ-022 In CAPTURE, the block SHALL register stk_value_out into rsp_data and pulse rsp_valid[winner] in the following cycle while returning to IDLE.
REQ-023 last_winner SHALL update only when ISSUE is entered.
REQ-024 Latency SHALL be: push request to gnt in 1 cycle; pop request to rsp_valid in 3 cycles from IDLE.
REQ-025 A requester with both push and pop asserted SHALL never be granted.
REQ-026 An ineligible request (push while full, pop while empty) SHALL wait and SHALL NOT be dropped.
REQ-027 The requester SHALL deassert its request in the cycle after gnt; behaviour if it does not is re-arbitration.
REQ-028 stk_push and stk_pop SHALL never be high simultaneously.

Reset
REQ-029 When reset is low at a clock edge, the state SHALL become IDLE and gnt, rsp_valid, stk_push, stk_pop, stk_value_in and rsp_data SHALL all be 0.
REQ-030 On reset, last_winner SHALL become NREQ-1, so requester 0 has first priority.
REQ-031 A reset asserted during ISSUE or CAPTURE SHALL abort the operation, with no rsp_valid pulse.

Configuration
REQ-032 When STACK_ARB_ERR_EN is defined, the block SHALL add output err (1 bit), set sticky on any cycle in IDLE where a requester has both push and pop asserted, push with stk_full, or pop with stk_empty, and cleared only by reset.
REQ-033 When STACK_ARB_ERR_EN is undefined, port err and its logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-034 Package stack_arb_pkg SHALL hold the state enum and the WIDTH and NREQ default constants.
REQ-035 Sub-module rr_pick SHALL implement the combinational round-robin picker, taking an eligible vector and last_winner and producing the winner index and an any-flag.

Verification
REQ-036 After reset, requester 0 pushes 16'h0013 -> gnt=2'b01 one cycle later, with stk_push=1 and stk_value_in=16'h0013 in the same cycle.
REQ-037 Both requesters push continuously (data 16'h0013 and 16'h0014) -> grants alternate 01,10,01,... one per 2 cycles, until stk_full holds requests.
REQ-038 With stack holding 16'h0013 on top, requester 1 pops -> rsp_valid=2'b10 and rsp_data=16'h0013 three cycles after the request.
REQ-039 Pop while stk_empty=1 -> no gnt; granted once a push lands; with STACK_ARB_ERR_EN, err=1 and sticky.
REQ-040 Requester 0 asserts push and pop together while requester 1 pushes 16'h0014 -> only requester 1 is granted.
REQ-041 Reset low during CAPTURE -> no rsp_valid, all outputs 0, and the next grant goes to requester 0.
